// File: rtl/dot_product_ctrl.sv
// Job sequencer for one pe_group of Para_Deg MAC lanes: clear, optional bias
// preload, operand streaming, pipeline drain, and result hand-off.
module dot_product_ctrl #(
    parameter int unsigned Data_Width = 8,
    parameter int unsigned Para_Deg   = 3,
    parameter int unsigned Len_Width  = 8,
    parameter int unsigned PE_Latency = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [Len_Width-1:0]                len,
    input  logic                                bias_en,
    input  logic [Para_Deg*2*Data_Width-1:0]    bias,
    output logic                                busy,
    output logic                                start_err,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [Para_Deg*Data_Width-1:0]      in_data0,
    input  logic [Para_Deg*Data_Width-1:0]      in_data1,
    output logic                                pe_reset,
    output logic                                pe_load_old_output,
    output logic [Para_Deg*Data_Width-1:0]      pe_data0,
    output logic [Para_Deg*Data_Width-1:0]      pe_data1,
    output logic [Para_Deg*2*Data_Width-1:0]    pe_old_output,
    input  logic [Para_Deg*2*Data_Width-1:0]    pe_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [Para_Deg*2*Data_Width-1:0]    out_result
);

    localparam int unsigned VEC_W   = Para_Deg * Data_Width;
    localparam int unsigned RES_W   = Para_Deg * 2 * Data_Width;
    localparam int unsigned DRAIN_W = $clog2(PE_Latency + 1) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD   = 3'd2,
        ACCUM  = 3'd3,
        DRAIN  = 3'd4,
        RESULT = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [Len_Width-1:0] len_q, len_d;
    logic [Len_Width-1:0] beat_cnt_q, beat_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 bias_en_q, bias_en_d;
    logic [RES_W-1:0]     bias_q, bias_d;

    logic                 busy_d, start_err_d, in_ready_d, out_valid_d;
    logic                 pe_reset_d, pe_load_d;
    logic [VEC_W-1:0]     pe_data0_d, pe_data1_d;
    logic [RES_W-1:0]     pe_old_d, out_result_d;

    // Next-state logic and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        bias_en_d    = bias_en_q;
        bias_d       = bias_q;
        start_err_d  = 1'b0;
        pe_data0_d   = '0;
        pe_data1_d   = '0;
        out_result_d = out_result;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d     = len;
                        bias_en_d = bias_en;
                        bias_d    = bias;
                        state_d   = CLEAR;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                beat_cnt_d = '0;
                state_d    = bias_en_q ? LOAD : ACCUM;
            end
            LOAD: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                if (in_valid && in_ready) begin
                    pe_data0_d = in_data0;
                    pe_data1_d = in_data1;
                    beat_cnt_d = beat_cnt_q + Len_Width'(1);
                    if ((beat_cnt_q + Len_Width'(1)) == len_q) begin
                        drain_cnt_d = '0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last beat needs PE_Latency cycles to land, plus one for its pe_data cycle.
                if (drain_cnt_q == DRAIN_W'(PE_Latency)) begin
                    out_result_d = pe_result;
                    state_d      = RESULT;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == RESULT);
        pe_reset_d  = (state_d == IDLE) || (state_d == CLEAR);
        pe_load_d   = (state_d == LOAD);
        pe_old_d    = (state_d == LOAD) ? bias_q : '0;
    end

    // State, job context and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= IDLE;
            len_q              <= '0;
            beat_cnt_q         <= '0;
            drain_cnt_q        <= '0;
            bias_en_q          <= 1'b0;
            bias_q             <= '0;
            busy               <= 1'b0;
            start_err          <= 1'b0;
            in_ready           <= 1'b0;
            out_valid          <= 1'b0;
            pe_reset           <= 1'b1;
            pe_load_old_output <= 1'b0;
            pe_data0           <= '0;
            pe_data1           <= '0;
            pe_old_output      <= '0;
            out_result         <= '0;
        end else begin
            state_q            <= state_d;
            len_q              <= len_d;
            beat_cnt_q         <= beat_cnt_d;
            drain_cnt_q        <= drain_cnt_d;
            bias_en_q          <= bias_en_d;
            bias_q             <= bias_d;
            busy               <= busy_d;
            start_err          <= start_err_d;
            in_ready           <= in_ready_d;
            out_valid          <= out_valid_d;
            pe_reset           <= pe_reset_d;
            pe_load_old_output <= pe_load_d;
            pe_data0           <= pe_data0_d;
            pe_data1           <= pe_data1_d;
            pe_old_output      <= pe_old_d;
            out_result         <= out_result_d;
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl with a behavioural pe_group model.
module tb_dot_product_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned PD    = 3;
    localparam int unsigned LW    = 8;
    localparam int unsigned VEC_W = PD * DW;
    localparam int unsigned RES_W = PD * 2 * DW;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LW-1:0]    len;
    logic             bias_en;
    logic [RES_W-1:0] bias;
    logic             busy, start_err;
    logic             in_valid, in_ready;
    logic [VEC_W-1:0] in_data0, in_data1;
    logic             pe_reset, pe_load_old_output;
    logic [VEC_W-1:0] pe_data0, pe_data1;
    logic [RES_W-1:0] pe_old_output, pe_result;
    logic             out_valid, out_ready;
    logic [RES_W-1:0] out_result;
    logic [RES_W-1:0] pe_acc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0]             len;
        logic                   bias_en;
        logic [2:0][15:0]       bias;
        logic [1:0][2:0][7:0]   d0;
        logic [1:0][2:0][7:0]   d1;
        logic [3:0]             gap;
        logic [2:0][15:0]       expv;
    } job_t;

    job_t jobs [5];

    dot_product_ctrl #(.Data_Width(DW), .Para_Deg(PD), .Len_Width(LW), .PE_Latency(1)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .bias_en(bias_en), .bias(bias),
        .busy(busy), .start_err(start_err), .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .pe_reset(pe_reset),
        .pe_load_old_output(pe_load_old_output), .pe_data0(pe_data0), .pe_data1(pe_data1),
        .pe_old_output(pe_old_output), .pe_result(pe_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result)
    );

    always #5 clk = ~clk;

    // pe_group model: one-cycle MAC per lane with bias select and clear.
    always_ff @(posedge clk) begin
        if (pe_reset) begin
            pe_acc <= '0;
        end else begin
            for (int i = 0; i < PD; i++) begin
                pe_acc[i*16 +: 16] <= (pe_load_old_output ? pe_old_output[i*16 +: 16] : pe_acc[i*16 +: 16])
                                    + 16'(pe_data0[i*8 +: 8]) * 16'(pe_data1[i*8 +: 8]);
            end
        end
    end
    assign pe_result = pe_acc;

    function automatic logic [23:0] l8(input int a0, input int a1, input int a2);
        return {8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [47:0] l16(input int a0, input int a1, input int a2);
        return {16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one job from the table; hold>0 stalls out_ready and pokes start meanwhile.
    task automatic run_job(input job_t j, input int hold);
        int loads;
        bit got;
        logic [RES_W-1:0] held;
        start = 1'b1; len = j.len; bias_en = j.bias_en; bias = j.bias;
        @(negedge clk);
        start = 1'b0; bias_en = 1'b0; bias = '0; len = '0;
        chk("busy_after_start", 64'(busy), 64'd1);
        loads = 0; got = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (in_ready) begin got = 1'b1; break; end
            if (pe_load_old_output) loads++;
            @(negedge clk);
        end
        chk("in_ready_rise", 64'(got), 64'd1);
        chk("load_pulses", 64'(loads), 64'(j.bias_en));
        for (int b = 0; b < int'(j.len); b++) begin
            in_valid = 1'b1; in_data0 = j.d0[b]; in_data1 = j.d1[b];
            @(negedge clk);
            in_valid = 1'b0; in_data0 = l8(99, 99, 99); in_data1 = l8(99, 99, 99);
            if (b < int'(j.len) - 1) begin
                for (int g = 0; g < int'(j.gap); g++) @(negedge clk);
            end
        end
        chk("in_ready_drop", 64'(in_ready), 64'd0);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin got = 1'b1; break; end
            chk("busy_drain", 64'(busy), 64'd1);
            @(negedge clk);
        end
        chk("out_valid_rise", 64'(got), 64'd1);
        for (int i = 0; i < PD; i++) chk($sformatf("lane%0d", i), 64'(out_result[i*16 +: 16]), 64'(j.expv[i]));
        held = out_result;
        for (int h = 0; h < hold; h++) begin
            start = 1'b1; len = (h % 2 == 1) ? 8'd3 : 8'd0;
            @(negedge clk);
            start = 1'b0;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'(out_result == held), 64'd1);
            chk("hold_no_err", 64'(start_err), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("busy_drop", 64'(busy), 64'd0);
    endtask

    initial begin
        // job table: {len, bias_en, bias, beats, gap, expected lanes}
        jobs[0] = '{8'd2, 1'b0, l16(0, 0, 0), {l8(4, 5, 6), l8(1, 2, 3)}, {l8(1, 1, 1), l8(2, 2, 2)}, 4'd0, l16(6, 9, 12)};
        jobs[1] = '{8'd1, 1'b1, l16(100, 200, 300), {l8(0, 0, 0), l8(10, 10, 10)}, {l8(0, 0, 0), l8(10, 20, 30)}, 4'd0, l16(200, 400, 600)};
        jobs[2] = '{8'd2, 1'b0, l16(0, 0, 0), {l8(4, 5, 6), l8(1, 2, 3)}, {l8(1, 1, 1), l8(2, 2, 2)}, 4'd3, l16(6, 9, 12)};
        jobs[3] = '{8'd2, 1'b0, l16(0, 0, 0), {l8(255, 1, 0), l8(255, 1, 0)}, {l8(255, 1, 0), l8(255, 1, 0)}, 4'd0, l16(64514, 2, 0)};
        jobs[4] = '{8'd1, 1'b1, l16(65535, 5, 0), {l8(0, 0, 0), l8(1, 0, 0)}, {l8(0, 0, 0), l8(1, 0, 0)}, 4'd0, l16(0, 5, 0)};

        reset = 1'b0; start = 1'b0; len = '0; bias_en = 1'b0; bias = '0;
        in_valid = 1'b0; in_data0 = '0; in_data1 = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pe_reset", 64'(pe_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        reset = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_stable", 64'({pe_reset, busy, in_ready, out_valid, start_err, pe_load_old_output}), 64'b100000);
            chk("idle_pe_data", 64'(pe_data0 | pe_data1), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b0;

        for (int k = 0; k < 5; k++) run_job(jobs[k], 0);

        // Stalled consumer with start pokes, then a zero-length request.
        run_job(jobs[0], 5);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_err", 64'(start_err), 64'd1);
        chk("len0_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("len0_err_pulse", 64'(start_err), 64'd0);
        chk("len0_idle", 64'(busy), 64'd0);

        // Maximum length job: 255 beats.
        start = 1'b1; len = 8'd255;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("max_ready", 64'(in_ready), 64'd1);
        for (int b = 0; b < 255; b++) begin
            if (b == 254) chk("max_ready_last", 64'(in_ready), 64'd1);
            in_valid = 1'b1; in_data0 = l8(1, 2, 3); in_data1 = l8(1, 1, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("max_ready_drop", 64'(in_ready), 64'd0);
        for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
        chk("max_lanes", 64'(out_result), 64'(l16(255, 510, 765)));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Abort mid-accumulation, then a clean job.
        start = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data0 = l8(7, 7, 7); in_data1 = l8(7, 7, 7);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_state", 64'({pe_reset, busy, in_ready, out_valid, pe_load_old_output}), 64'b10000);
        chk("abort_data", 64'(pe_data0 | pe_data1), 64'd0);
        chk("abort_result", 64'(out_result), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_job('{8'd1, 1'b0, l16(0, 0, 0), {l8(0, 0, 0), l8(2, 3, 4)}, {l8(0, 0, 0), l8(1, 1, 1)}, 4'd0, l16(2, 3, 4)}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_ctrl.md
Name: dot_product_ctrl

Overview:
- Sequencer for one pe_group of Para_Deg multiply-accumulate lanes.
- Takes a job command of vector length (in Para_Deg-wide beats) plus an optional per-lane bias.
- Clears the PE group, optionally preloads the bias through old_output/load_old_output, streams operand beats into the group, and waits out the PE pipeline.
- Returns the captured per-lane accumulations over a valid/ready result port.

Parameters:
- Data_Width, 8, operand width per lane; accumulator/result width per lane is 2*Data_Width.
- Para_Deg, 3, number of PE lanes.
- Len_Width, 8, width of the job length field (beats).
- PE_Latency, 1, cycles from PE input to updated pe_result.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled in IDLE only
- len  in  Len_Width  number of operand beats in the job
- bias_en  in  1  preload bias before accumulation
- bias  in  Para_Deg*2*Data_Width  per-lane bias; lane i at [2*i*Data_Width +: 2*Data_Width]
- busy  out  1  high in every non-IDLE state
- start_err  out  1  one-cycle pulse when start is seen with len==0
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid&in_ready
- in_data0  in  Para_Deg*Data_Width  lane operands A; lane i at [i*Data_Width +: Data_Width]
- in_data1  in  Para_Deg*Data_Width  lane operands B
- pe_reset  out  1  active-high clear to pe_group
- pe_load_old_output  out  1  pe_group accumulator source select
- pe_data0  out  Para_Deg*Data_Width  registered operands A to pe_group
- pe_data1  out  Para_Deg*Data_Width  registered operands B to pe_group
- pe_old_output  out  Para_Deg*2*Data_Width  bias to pe_group
- pe_result  in  Para_Deg*2*Data_Width  pe_group accumulations
- out_valid  out  1  result available
- out_ready  in  1  result consumer ready
- out_result  out  Para_Deg*2*Data_Width  captured per-lane results

Behaviour:
- PE contract: each cycle, result <= (load_old_output ? old_output : result) + data0*data1 per lane, mod 2^(2*Data_Width). pe_reset clears result to 0.
- All outputs are registered.
- Reset (asserted low, async) state: IDLE, pe_reset=1, all other outputs 0, beat counter 0, out_result 0.
- IDLE
  - busy=0, in_ready=0, pe_reset=1, pe_data* = 0.
  - start & len!=0: latch len/bias_en/bias, go to CLEAR.
  - start & len==0: start_err=1 for one cycle, stay in IDLE.
- CLEAR (1 cycle)
  - pe_reset=1.
  - Next state is LOAD if bias_en, else ACCUM.
- LOAD (1 cycle)
  - pe_reset=0, pe_load_old_output=1, pe_old_output=bias, pe_data*=0.
  - Go to ACCUM.
- ACCUM
  - pe_reset=0, pe_load_old_output=0, in_ready=1.
  - Accepted beat: pe_data0/1 take in_data0/1 next cycle and the counter increments.
  - No beat: pe_data* = 0 next cycle, so the accumulation is unchanged.
  - When the accepted beat is number len: in_ready drops the next cycle, go to DRAIN.
- DRAIN
  - pe_data*=0 for PE_Latency+1 cycles, then capture pe_result into out_result and go to RESULT.
- RESULT
  - out_valid=1, out_result held stable, in_ready=0.
  - On out_valid&out_ready: out_valid=0 next cycle, go to IDLE.
- start is ignored while busy and does not pulse start_err.
- in_valid outside ACCUM is ignored.
- out_ready outside RESULT is ignored.
- Counter is Len_Width bits; len=2^Len_Width-1 must complete correctly.
- Arithmetic wraps; no saturation and no overflow flag.
- Reset mid-job aborts immediately to the reset state. No partial result is emitted.

Test Plan:
- Reset with no job: pe_reset=1, busy=0, in_ready=0, out_valid=0, out_result=0. After release, no output changes until start.
- len=2, bias_en=0, Data_Width=8, Para_Deg=3. Beats:
  - data0 lanes{1,2,3}, data1 lanes{2,2,2}
  - then data0 lanes{4,5,6}, data1 lanes{1,1,1}
  - Required: out_result lanes{6,9,12}, busy high from the cycle after start until the handshake completes.
- bias_en=1, bias lanes{100,200,300}, len=1, data0{10,10,10}, data1{10,20,30}:
  - Exactly one cycle with pe_load_old_output=1 before in_ready rises.
  - Required: out_result lanes{200,400,600}.
- Same as scenario 2 with in_valid low for 3 cycles between the beats: result still {6,9,12}, only accepted beats are counted. len=2 beats of 255*255 on lane 0 -> lane 0 = 130050 mod 65536 = 64514.
- out_ready held low 5 cycles in RESULT: out_valid stays 1 and out_result is stable; start pulses meanwhile are ignored. After the handshake, start with len=0 -> start_err pulses once, busy stays 0.
- reset asserted during ACCUM after 1 of 3 beats: all outputs go to reset values immediately. A fresh len=1 job afterwards produces only its own products, with no residue from the aborted job.
